// File: rtl/sram_ctl.sv
// sram_ctl: clocked sequencer for an asynchronous SRAM driven from an
// asynchronous host strobe bus, with synchronised strobes and wait states.
module sram_ctl #(
  parameter int ADDR_WIDTH     = 7,
  parameter int MEM_ADDR_WIDTH = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int SETUP_CYCLES   = 1,
  parameter int WRITE_CYCLES   = 4,
  parameter int READ_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce_n,
  input  logic                      read_n,
  input  logic                      write_n,
  input  logic [ADDR_WIDTH-1:0]     address_bus,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      done,
  output logic                      busy,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0]     mem_data,
  output logic                      ceh_n,
  output logic                      ce2,
  output logic                      we_n,
  output logic                      oe_n
);

  localparam int MAX_SW  = (SETUP_CYCLES > WRITE_CYCLES) ? SETUP_CYCLES : WRITE_CYCLES;
  localparam int MAX_CYC = (MAX_SW > READ_CYCLES) ? MAX_SW : READ_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_END,
    ST_WAIT
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      op_wr_q, op_wr_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]                ce_sync_q, rd_sync_q, wr_sync_q;

  logic ce_s, rd_s, wr_s;
  logic req_ok;
  logic ce_act;

  assign ce_s = ce_sync_q[1];
  assign rd_s = rd_sync_q[1];
  assign wr_s = wr_sync_q[1];
  // Exactly one of read/write asserted; both or neither is not a request.
  assign req_ok = !ce_s && (rd_s != wr_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_sync_q <= 2'b11;
      rd_sync_q <= 2'b11;
      wr_sync_q <= 2'b11;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= '0;
    end else begin
      ce_sync_q <= {ce_sync_q[0], ce_n};
      rd_sync_q <= {rd_sync_q[0], read_n};
      wr_sync_q <= {wr_sync_q[0], write_n};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          state_d = ST_SETUP;
          op_wr_d = !wr_s;
          addr_d  = MEM_ADDR_WIDTH'(address_bus);
          wdata_d = wdata;
          cnt_d   = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = op_wr_q ? WRITE_LOAD : READ_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_END;
          if (!op_wr_q) rdata_d = mem_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_END:  state_d = ST_WAIT;
      // A host still holding ce_n low parks here until it lets go.
      ST_WAIT: if (ce_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ce_act      = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_END);
  assign ceh_n       = !ce_act;
  assign ce2         = ce_act;
  assign we_n        = !((state_q == ST_STROBE) && op_wr_q);
  assign oe_n        = !((state_q == ST_STROBE) && !op_wr_q);
  assign done        = (state_q == ST_END);
  assign busy        = (state_q != ST_IDLE);
  assign mem_address = addr_q;
  assign rdata       = rdata_q;
  // Data bus is only ever driven for writes, so it never fights oe_n.
  assign mem_data    = (ce_act && op_wr_q) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_ctl.sv
// Bench for sram_ctl: random host traffic against a queue-based scoreboard
// and array memory model, plus a scaled-timing instance with 16-bit data.
`timescale 1ns/1ps
module tb_sram_ctl;
  localparam int SA = 1, WA = 4, RA = 2;
  localparam int SB = 2, WB = 6, RB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- instance A: default parameters ----------------
  logic        rst_a = 1'b1, ce_n_a = 1'b1, rd_n_a = 1'b1, wr_n_a = 1'b1;
  logic [6:0]  addr_a = '0;
  logic [7:0]  wdata_a = '0, rdata_a;
  logic        done_a, busy_a, ceh_n_a, ce2_a, we_n_a, oe_n_a;
  logic [16:0] maddr_a;
  wire  [7:0]  md_a;

  sram_ctl dut_a (
    .clk(clk), .reset(rst_a), .ce_n(ce_n_a), .read_n(rd_n_a), .write_n(wr_n_a),
    .address_bus(addr_a), .wdata(wdata_a), .rdata(rdata_a), .done(done_a),
    .busy(busy_a), .mem_address(maddr_a), .mem_data(md_a), .ceh_n(ceh_n_a),
    .ce2(ce2_a), .we_n(we_n_a), .oe_n(oe_n_a)
  );

  function automatic logic [7:0] init_a(int i);
    return 8'(i * 7 + 3);
  endfunction

  logic [7:0] sram_a [128];
  logic [7:0] ref_a  [128];
  initial for (int i = 0; i < 128; i++) begin sram_a[i] = init_a(i); ref_a[i] = init_a(i); end
  assign md_a = (!oe_n_a && !ceh_n_a && ce2_a) ? sram_a[maddr_a[6:0]] : 8'bz;
  always @(posedge we_n_a) if (!rst_a) sram_a[maddr_a[6:0]] <= md_a;

  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] data;
    int         done_cyc;
    logic [7:0] rd_hold;
  } exp_t;
  exp_t sbq[$];
  logic [7:0] last_rd = '0;
  int n_issued = 0, n_done = 0;
  int we_cnt = 0, oe_cnt = 0, ce_cnt = 0;

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_a) begin
      we_cnt = 0; oe_cnt = 0; ce_cnt = 0;
    end else begin
      if (!we_n_a) we_cnt++;
      if (!oe_n_a) oe_cnt++;
      if (!ceh_n_a && ce2_a) ce_cnt++;
      if (!we_n_a && !oe_n_a) chk("we_oe_overlap", 1, 0);
      if (done_a) begin
        n_done++;
        if (sbq.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("mem_address", longint'(maddr_a), longint'({10'd0, e.addr}));
          chk("we_low_cycles", we_cnt, e.wr ? WA : 0);
          chk("oe_low_cycles", oe_cnt, e.wr ? 0 : RA);
          chk("ce_cycles", ce_cnt, SA + (e.wr ? WA : RA) + 1);
          if (e.wr) begin
            chk("mem_data_write", longint'(md_a), longint'(e.data));
            chk("rdata_hold", longint'(rdata_a), longint'(e.rd_hold));
          end else begin
            chk("rdata_read", longint'(rdata_a), longint'(e.data));
          end
        end
        we_cnt = 0; oe_cnt = 0; ce_cnt = 0;
      end
    end
  end

  task automatic issue_a(bit wr, logic [6:0] a, logic [7:0] d, int hold);
    exp_t e;
    bit   seen;
    @(negedge clk);
    addr_a = a; wdata_a = d; ce_n_a = 1'b0; rd_n_a = wr; wr_n_a = !wr;
    e.wr = wr; e.addr = a; e.done_cyc = cyc + 3 + SA + (wr ? WA : RA);
    if (wr) begin ref_a[a] = d; e.data = d; e.rd_hold = last_rd; end
    else begin e.data = ref_a[a]; e.rd_hold = ref_a[a]; last_rd = ref_a[a]; end
    sbq.push_back(e);
    n_issued++;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done_a;
    end
    if (!seen) chk("done_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    if (hold > 0) chk("held_ce_stays_wait", busy_a, 1);
    ce_n_a = 1'b1; rd_n_a = 1'b1; wr_n_a = 1'b1;
    for (int i = 0; i < 10 && busy_a; i++) @(negedge clk);
    chk("return_idle", busy_a, 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // ---------------- instance B: scaled timing, 16-bit data ----------------
  logic        rst_b = 1'b1, ce_n_b = 1'b1, rd_n_b = 1'b1, wr_n_b = 1'b1;
  logic [6:0]  addr_b = '0;
  logic [15:0] wdata_b = '0, rdata_b;
  logic        done_b, busy_b, ceh_n_b, ce2_b, we_n_b, oe_n_b;
  logic [16:0] maddr_b;
  wire  [15:0] md_b;

  sram_ctl #(.DATA_WIDTH(16), .SETUP_CYCLES(SB), .WRITE_CYCLES(WB), .READ_CYCLES(RB)) dut_b (
    .clk(clk), .reset(rst_b), .ce_n(ce_n_b), .read_n(rd_n_b), .write_n(wr_n_b),
    .address_bus(addr_b), .wdata(wdata_b), .rdata(rdata_b), .done(done_b),
    .busy(busy_b), .mem_address(maddr_b), .mem_data(md_b), .ceh_n(ceh_n_b),
    .ce2(ce2_b), .we_n(we_n_b), .oe_n(oe_n_b)
  );

  logic [15:0] sram_b [128];
  initial for (int i = 0; i < 128; i++) sram_b[i] = 16'(i);
  assign md_b = (!oe_n_b && !ceh_n_b && ce2_b) ? sram_b[maddr_b[6:0]] : 16'bz;
  always @(posedge we_n_b) if (!rst_b) sram_b[maddr_b[6:0]] <= md_b;

  task automatic op_b(bit wr, logic [6:0] a, logic [15:0] d, output int dcyc,
                      output int wec, output int oec, output int cec, output logic [15:0] md_done);
    int start;
    @(negedge clk);
    addr_b = a; wdata_b = d; ce_n_b = 1'b0; rd_n_b = wr; wr_n_b = !wr;
    start = cyc; dcyc = -1; wec = 0; oec = 0; cec = 0; md_done = '0;
    for (int i = 0; i < 60 && dcyc < 0; i++) begin
      @(negedge clk);
      if (!we_n_b) wec++;
      if (!oe_n_b) oec++;
      if (!ceh_n_b && ce2_b) cec++;
      if (done_b) begin dcyc = cyc - start; md_done = md_b; end
    end
    ce_n_b = 1'b1; rd_n_b = 1'b1; wr_n_b = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, wc, oc, cc, done_snap;
    logic [15:0] mdd;
    bit seen;

    repeat (3) @(negedge clk);
    chk("reset_ctrl_a", longint'({ceh_n_a, ce2_a, we_n_a, oe_n_a, done_a, busy_a}), 6'b101100);
    chk("reset_addr_a", longint'(maddr_a), 0);
    chk("reset_rdata_a", longint'(rdata_a), 0);
    chk("reset_ctrl_b", longint'({ceh_n_b, ce2_b, we_n_b, oe_n_b, done_b, busy_b}), 6'b101100);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    issue_a(1'b1, 7'h55, 8'hA5, 0);
    issue_a(1'b0, 7'h55, 8'h00, 0);

    // Both strobes low, then neither low: never a request.
    ce_n_a = 1'b0; rd_n_a = 1'b0; wr_n_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("both_low_idle", longint'({busy_a, we_n_a, oe_n_a, ceh_n_a}), 4'b0111);
    end
    rd_n_a = 1'b1; wr_n_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("none_low_idle", longint'({busy_a, we_n_a, oe_n_a, ceh_n_a}), 4'b0111);
    end
    ce_n_a = 1'b1;
    repeat (3) @(negedge clk);

    done_snap = n_done;
    issue_a(1'b1, 7'h21, 8'h3C, 10);
    chk("held_single_access", n_done - done_snap, 1);
    issue_a(1'b0, 7'h21, 8'h00, 0);

    for (int i = 0; i < 40; i++)
      issue_a(1'($urandom_range(0, 1)), 7'($urandom_range(0, 63)), 8'($urandom), 0);

    // Reset during the write strobe abandons the access.
    done_snap = n_done;
    @(negedge clk);
    addr_a = 7'h7F; wdata_a = 8'h99; ce_n_a = 1'b0; rd_n_a = 1'b1; wr_n_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !we_n_a;
    end
    chk("abort_reached_strobe_a", seen, 1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("abort_ctrl_a", longint'({we_n_a, oe_n_a, ceh_n_a, ce2_a, busy_a, done_a}), 6'b111000);
    ce_n_a = 1'b1; wr_n_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    last_rd = '0;
    repeat (6) @(negedge clk);
    chk("abort_no_done_a", n_done - done_snap, 0);
    issue_a(1'b0, 7'h55, 8'h00, 0);

    // Scaled timing instance.
    op_b(1'b1, 7'h12, 16'hBEEF, dc, wc, oc, cc, mdd);
    chk("b_write_done_at", dc, 3 + SB + WB);
    chk("b_we_low", wc, WB);
    chk("b_oe_low_on_write", oc, 0);
    chk("b_ce_cycles", cc, SB + WB + 1);
    chk("b_mem_data", longint'(mdd), 16'hBEEF);
    chk("b_rdata_unchanged", longint'(rdata_b), 0);
    op_b(1'b0, 7'h12, 16'h0000, dc, wc, oc, cc, mdd);
    chk("b_read_done_at", dc, 3 + SB + RB);
    chk("b_oe_low", oc, RB);
    chk("b_we_low_on_read", wc, 0);
    chk("b_rdata", longint'(rdata_b), 16'hBEEF);
    @(negedge clk);
    addr_b = 7'h7E; wdata_b = 16'h1234; ce_n_b = 1'b0; rd_n_b = 1'b1; wr_n_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !we_n_b;
    end
    chk("b_abort_reached_strobe", seen, 1);
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_abort_ctrl", longint'({we_n_b, oe_n_b, ceh_n_b, ce2_b, busy_b, done_b}), 6'b111000);
    chk("b_abort_rdata", longint'(rdata_b), 0);
    ce_n_b = 1'b1; wr_n_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | done_b | busy_b;
    end
    chk("b_abort_quiet", seen, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("done_count", n_done, n_issued);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
